exhaustive_error_checker: RTL
=============================

Name: exhaustive_error_checker

Overview:
- Sequential test harness for a 4-input approximate circuit and its exact twin.
- Sweeps every input vector into both circuits and samples their outputs.
- Computes the per-vector absolute error and accumulates max, sum, violation count and first failing vector against an error threshold.
- Sits directly around the approximate stage: its vector output feeds that stage's inputs, and it consumes that stage's outputs.

Parameters:
- N_IN, 4: width of the input vector driven to the circuits under check.
- N_OUT, 2: width of the exact and approximate output words, interpreted as unsigned integers.
- ET, 1: error threshold, range 0..2^N_OUT-1. A vector violates when its error is greater than ET.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- vec_out  out  N_IN  registered input vector driven to both circuits.
- exact_in  in  N_OUT  exact circuit output, a combinational function of vec_out.
- approx_in  in  N_OUT  approximate circuit output, a combinational function of vec_out.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE; results are valid and stable.
- pass  out  1  done and viol_cnt==0.
- max_err  out  N_OUT  worst-case absolute error.
- sum_err  out  N_IN+N_OUT  sum of absolute errors over all vectors.
- viol_cnt  out  N_IN+1  number of vectors with error greater than ET.
- fail_seen  out  1  at least one violation recorded.
- first_fail_vec  out  N_IN  lowest vector that violated; 0 if none.

Behaviour:
- Reset: one clock is synchronous and active-high.
  - Every register clears: state=IDLE, vec_out=0, busy=0, done=0, pass=0, max_err=0, sum_err=0, viol_cnt=0, fail_seen=0, first_fail_vec=0, sample stage invalid.
  - Reset overrides start, and aborts any sweep in progress with no partial results retained.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> SWEEP. On the same edge:
  - vec_out<=0.
  - All accumulators, fail_seen and first_fail_vec clear.
  - done<=0.
- SWEEP, each edge:
  - Sample stage captures {s_valid=1, s_vec=vec_out, s_ex=exact_in, s_ap=approx_in}.
  - If vec_out==2^N_IN-1: vec_out holds and state->DRAIN.
  - Otherwise vec_out<=vec_out+1.
  - start is ignored.
- DRAIN: one edge to accumulate the final sample; s_valid<=0; ->DONE. start is ignored.
- DONE: outputs held.
  - start=1 -> SWEEP, with the same clearing as from IDLE.
  - done falls on that edge.
- Accumulate, on every edge where s_valid=1:
  - err=|s_ex-s_ap|, computed unsigned in N_OUT bits with no overflow. Implement as a compare-then-subtract.
  - max_err<=max(max_err,err).
  - sum_err<=sum_err+err. Width is sufficient and never wraps; maximum is 2^N_IN*(2^N_OUT-1).
  - If err>ET: viol_cnt++. If fail_seen==0, first_fail_vec<=s_vec and fail_seen<=1.
- Latency: start sampled at edge E0.
  - Vector k is presented after edge E_k.
  - The last sample is captured at E_(2^N_IN) and accumulated at E_(2^N_IN+1).
  - done=1 after E_(2^N_IN+1), i.e. 17 edges for N_IN=4.
- pass is registered and updates on the same edge as done.
- vec_out is never presented beyond 2^N_IN-1 (no wrap during a sweep).
- The combinational path vec_out -> DUT -> exact_in/approx_in must settle within one cycle; there are no other handshakes.

Test Plan:
- approx_in tied to exact_in = vec_out[1:0], start pulse -> done after 17 edges; max_err=0, sum_err=0, viol_cnt=0, fail_seen=0, pass=1.
- exact_in=vec_out[1:0], approx_in=0, ET=1 -> max_err=3, sum_err=24, viol_cnt=8, first_fail_vec=2, fail_seen=1, pass=0.
- Same stimulus with start re-pulsed during SWEEP at vec_out=5 -> ignored; identical results and done timing.
- rst asserted for one cycle at vec_out=9 -> next cycle IDLE with all outputs 0; new start gives a full correct sweep.
- From DONE, pulse start -> done falls on that edge, accumulators clear, and the sweep repeats with identical results.
- exact_in=3, approx_in=0 only at vec_out=15, else equal; ET=2 -> viol_cnt=1, first_fail_vec=15, max_err=3, sum_err=3; checks final-sample drain.

Source files
------------

// File: rtl/exhaustive_error_checker.sv
// Sweeps every N_IN-bit vector through an exact/approximate circuit pair and
// accumulates worst-case error, total error, violation count and first failing vector.
module exhaustive_error_checker #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int ET    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         vec_out,
    input  logic [N_OUT-1:0]        exact_in,
    input  logic [N_OUT-1:0]        approx_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_OUT-1:0]        max_err,
    output logic [N_IN+N_OUT-1:0]   sum_err,
    output logic [N_IN:0]           viol_cnt,
    output logic                    fail_seen,
    output logic [N_IN-1:0]         first_fail_vec,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_OUT-1:0] ET_W     = N_OUT'(ET);

    state_t                  state_q, state_d;
    logic [N_IN-1:0]         vec_q, vec_d;
    logic                    s_valid_q, s_valid_d;
    logic [N_IN-1:0]         s_vec_q, s_vec_d;
    logic [N_OUT-1:0]        s_ex_q, s_ex_d;
    logic [N_OUT-1:0]        s_ap_q, s_ap_d;
    logic [N_OUT-1:0]        max_q, max_d;
    logic [N_IN+N_OUT-1:0]   sum_q, sum_d;
    logic [N_IN:0]           viol_q, viol_d;
    logic                    fail_seen_q, fail_seen_d;
    logic [N_IN-1:0]         first_q, first_d;
    logic                    pass_q, pass_d;

    logic [N_OUT-1:0]        err_c;
    logic                    start_sweep;

    // Compare-then-subtract keeps the absolute error in N_OUT bits without a sign bit.
    assign err_c = (s_ex_q >= s_ap_q) ? (s_ex_q - s_ap_q) : (s_ap_q - s_ex_q);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        s_valid_d   = s_valid_q;
        s_vec_d     = s_vec_q;
        s_ex_d      = s_ex_q;
        s_ap_d      = s_ap_q;
        max_d       = max_q;
        sum_d       = sum_q;
        viol_d      = viol_q;
        fail_seen_d = fail_seen_q;
        first_d     = first_q;
        pass_d      = pass_q;
        start_sweep = 1'b0;

        if (s_valid_q) begin
            if (err_c > max_q) begin
                max_d = err_c;
            end
            sum_d = sum_q + {{N_IN{1'b0}}, err_c};
            if (err_c > ET_W) begin
                viol_d = viol_q + (N_IN+1)'(1);
                if (!fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    first_d     = s_vec_q;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SWEEP;
                    start_sweep = 1'b1;
                end
            end
            S_SWEEP: begin
                s_valid_d = 1'b1;
                s_vec_d   = vec_q;
                s_ex_d    = exact_in;
                s_ap_d    = approx_in;
                // Hold the last vector rather than wrapping while it drains.
                if (vec_q == VEC_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    vec_d = vec_q + N_IN'(1);
                end
            end
            S_DRAIN: begin
                s_valid_d = 1'b0;
                state_d   = S_DONE;
                pass_d    = (viol_d == '0);
            end
            S_DONE: begin
                if (start) begin
                    state_d     = S_SWEEP;
                    start_sweep = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_sweep) begin
            vec_d       = '0;
            s_valid_d   = 1'b0;
            max_d       = '0;
            sum_d       = '0;
            viol_d      = '0;
            fail_seen_d = 1'b0;
            first_d     = '0;
            pass_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            s_valid_q   <= 1'b0;
            s_vec_q     <= '0;
            s_ex_q      <= '0;
            s_ap_q      <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            viol_q      <= '0;
            fail_seen_q <= 1'b0;
            first_q     <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            s_valid_q   <= s_valid_d;
            s_vec_q     <= s_vec_d;
            s_ex_q      <= s_ex_d;
            s_ap_q      <= s_ap_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            viol_q      <= viol_d;
            fail_seen_q <= fail_seen_d;
            first_q     <= first_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign max_err        = max_q;
    assign sum_err        = sum_q;
    assign viol_cnt       = viol_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_vec = first_q;
    assign state_dbg      = state_q;

endmodule
